// File: rtl/load_store_unit.sv
// load_store_unit: adapts RV32I byte/halfword/word loads and stores onto a
// memory that only reads and writes aligned 32-bit words. Sub-word stores
// use a read-modify-write sequence. Misaligned or illegal requests complete
// with an error and make no memory access.
module load_store_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_MemWrite,
    output logic        mem_MemRead,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic        r_write;
    logic [31:0] r_old;
    logic [31:0] r_rdata;
    logic        r_error;

    logic        w_accept;
    logic        w_legal;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_merged;

    assign w_accept = req_valid && (r_state == ST_IDLE);

    // Legality of the incoming request: funct3 must exist for the direction,
    // and halfword/word accesses must be naturally aligned.
    always_comb begin
        w_legal = 1'b0;
        case (req_funct3)
            3'b000:  w_legal = 1'b1;
            3'b001:  w_legal = ~req_addr[0];
            3'b010:  w_legal = (req_addr[1:0] == 2'b00);
            3'b100:  w_legal = ~req_write;
            3'b101:  w_legal = ~req_write & ~req_addr[0];
            default: w_legal = 1'b0;
        endcase
    end

    // Lane selection and sign/zero extension of the word returned by memory.
    always_comb begin
        w_byte = 8'h00;
        case (r_addr[1:0])
            2'b00:   w_byte = mem_read_data[7:0];
            2'b01:   w_byte = mem_read_data[15:8];
            2'b10:   w_byte = mem_read_data[23:16];
            default: w_byte = mem_read_data[31:24];
        endcase
        w_half = r_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        w_load_ext = mem_read_data;
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_ext = {24'h000000, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_ext = {16'h0000, w_half};
            default: w_load_ext = mem_read_data;
        endcase
    end

    // Store word: the old word with the addressed lane replaced, or rs2 for SW.
    always_comb begin
        w_merged = r_old;
        case (r_funct3)
            3'b000: begin
                case (r_addr[1:0])
                    2'b00:   w_merged[7:0]   = r_wdata[7:0];
                    2'b01:   w_merged[15:8]  = r_wdata[7:0];
                    2'b10:   w_merged[23:16] = r_wdata[7:0];
                    default: w_merged[31:24] = r_wdata[7:0];
                endcase
            end
            3'b001: begin
                if (r_addr[1]) begin
                    w_merged[31:16] = r_wdata[15:0];
                end else begin
                    w_merged[15:0] = r_wdata[15:0];
                end
            end
            default: w_merged = r_wdata;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection and per-state memory/handshake outputs.
    always_comb begin
        w_next_state   = r_state;
        req_ready      = 1'b0;
        busy           = 1'b1;
        rsp_valid      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_MemWrite   = 1'b0;
        mem_MemRead    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (w_accept) begin
                    if (!w_legal) begin
                        w_next_state = ST_RESP;
                    end else if (!req_write) begin
                        w_next_state = ST_LOAD;
                    end else if (req_funct3 == 3'b010) begin
                        w_next_state = ST_WRITE;
                    end else begin
                        w_next_state = ST_READ;
                    end
                end
            end
            ST_LOAD: begin
                mem_address  = {r_addr[31:2], 2'b00};
                mem_MemRead  = 1'b1;
                w_next_state = ST_RESP;
            end
            ST_READ: begin
                mem_address  = {r_addr[31:2], 2'b00};
                mem_MemRead  = 1'b1;
                w_next_state = ST_WRITE;
            end
            ST_WRITE: begin
                mem_address    = {r_addr[31:2], 2'b00};
                mem_write_data = w_merged;
                // Gated so a reset landing on this cycle commits nothing.
                mem_MemWrite   = reset_n;
                w_next_state   = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid    = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Request capture, old-word capture and response registers. Response
    // values are written only in the cycle before RESP so they hold steady
    // until the next response.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_funct3 <= '0;
            r_write  <= 1'b0;
            r_old    <= '0;
            r_rdata  <= '0;
            r_error  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_funct3 <= req_funct3;
                        r_write  <= req_write;
                        if (!w_legal) begin
                            r_rdata <= '0;
                            r_error <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    r_rdata <= w_load_ext;
                    r_error <= 1'b0;
                end
                ST_READ: begin
                    r_old <= mem_read_data;
                end
                ST_WRITE: begin
                    r_rdata <= '0;
                    r_error <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_error = r_error;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a behavioural word memory, a table of requests
// with expected responses fed through a scoreboard queue, and hand-written
// sequences for reset during WRITE and back-to-back held requests.
module tb_load_store_unit;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_MemWrite;
    logic        mem_MemRead;
    logic [31:0] mem_read_data;

    load_store_unit dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .busy           (busy),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_error      (rsp_error),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_MemWrite   (mem_MemWrite),
        .mem_MemRead    (mem_MemRead),
        .mem_read_data  (mem_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word memory: combinational read, write committed at the rising edge.
    logic [31:0] mem [0:63];
    assign mem_read_data = mem[mem_address[7:2]];
    always @(posedge clock) begin
        if (mem_MemWrite) mem[mem_address[7:2]] <= mem_write_data;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] er,
                                input logic ee, input int el);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
        return v;
    endfunction

    // One request: push expectation, drive, wait (bounded) for the response,
    // pop and compare, then confirm the response registers hold.
    task automatic run_req(input string name, input vec_t v);
        exp_t e;
        exp_t x;
        bit   got;
        int   lat;
        bit   en_seen;
        bit   both_seen;
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat;
        sb.push_back(e);
        @(negedge clock);
        check({name, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(posedge clock);
        #1 req_valid = 1'b0;
        got = 0; lat = 0; en_seen = 0; both_seen = 0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge clock);
            if (mem_MemRead || mem_MemWrite) en_seen = 1;
            if (mem_MemRead && mem_MemWrite) both_seen = 1;
            if (rsp_valid) begin
                got = 1;
                lat = c;
            end
        end
        x = sb.pop_front();
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no rsp_valid within 10 cycles, expected latency %0d", name, x.lat);
        end else begin
            check({name, "_rdata"}, rsp_rdata, x.rdata);
            check({name, "_error"}, {31'd0, rsp_error}, {31'd0, x.err});
            check({name, "_latency"}, lat, x.lat);
            check({name, "_rd_wr_excl"}, {31'd0, both_seen}, 32'd0);
            if (x.err) check({name, "_no_mem_access"}, {31'd0, en_seen}, 32'd0);
            @(negedge clock);
            check({name, "_pulse_one_cycle"}, {31'd0, rsp_valid}, 32'd0);
            check({name, "_rdata_hold"}, rsp_rdata, x.rdata);
        end
    endtask

    initial begin
        int acc_cyc [3];
        int nacc;
        int nrsp;
        bit acc;
        bit wr_during_rst;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;

        vecs[0]  = mk(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2);
        vecs[1]  = mk(0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2);
        vecs[2]  = mk(1, 3'b000, 32'h11, 32'h00000055, 32'h0,        0, 3);
        vecs[3]  = mk(0, 3'b010, 32'h10, 32'h0,        32'hDEAD55EF, 0, 2);
        vecs[4]  = mk(0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 2);
        vecs[5]  = mk(0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 0, 2);
        vecs[6]  = mk(1, 3'b010, 32'h10, 32'h11223344, 32'h0,        0, 2);
        vecs[7]  = mk(1, 3'b001, 32'h12, 32'h00008001, 32'h0,        0, 3);
        vecs[8]  = mk(0, 3'b010, 32'h10, 32'h0,        32'h80013344, 0, 2);
        vecs[9]  = mk(0, 3'b001, 32'h12, 32'h0,        32'hFFFF8001, 0, 2);
        vecs[10] = mk(0, 3'b101, 32'h12, 32'h0,        32'h00008001, 0, 2);
        vecs[11] = mk(0, 3'b000, 32'h10, 32'h0,        32'h00000044, 0, 2);
        vecs[12] = mk(0, 3'b001, 32'h10, 32'h0,        32'h00003344, 0, 2);
        vecs[13] = mk(0, 3'b000, 32'h11, 32'h0,        32'h00000033, 0, 2);
        vecs[14] = mk(0, 3'b010, 32'h02, 32'h0,        32'h0,        1, 1);
        vecs[15] = mk(1, 3'b001, 32'h01, 32'h0000FFFF, 32'h0,        1, 1);
        vecs[16] = mk(0, 3'b011, 32'h00, 32'h0,        32'h0,        1, 1);
        vecs[17] = mk(1, 3'b100, 32'h00, 32'h0,        32'h0,        1, 1);
        vecs[18] = mk(0, 3'b001, 32'h13, 32'h0,        32'h0,        1, 1);
        vecs[19] = mk(1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0,        0, 2);

        // Reset values.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_busy",      {31'd0, busy},         32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid},    32'd0);
        check("rst_rsp_error", {31'd0, rsp_error},    32'd0);
        check("rst_rsp_rdata", rsp_rdata,             32'd0);
        check("rst_mem_read",  {31'd0, mem_MemRead},  32'd0);
        check("rst_mem_write", {31'd0, mem_MemWrite}, 32'd0);
        check("rst_mem_addr",  mem_address,           32'd0);
        check("rst_mem_wdata", mem_write_data,        32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < NV; i++) run_req($sformatf("vec%0d", i), vecs[i]);

        // Reset arriving during the WRITE cycle of a SW must commit nothing.
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clock);
        #1 req_valid = 1'b0;
        check("rstw_in_write_busy", {31'd0, busy}, 32'd1);
        #1 reset_n = 1'b0;
        @(negedge clock);
        wr_during_rst = mem_MemWrite;
        check("rstw_memwrite_gated", {31'd0, wr_during_rst}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        check("rstw_busy",      {31'd0, busy},      32'd0);
        check("rstw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rstw_mem_addr",  mem_address,        32'd0);
        check("rstw_mem_word",  mem[8],             32'hCAFEF00D);
        reset_n = 1'b1;
        @(negedge clock);
        check("rstw_no_response", {31'd0, rsp_valid}, 32'd0);
        run_req("rstw_readback", mk(0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 0, 2));

        // Three SB requests with req_valid held high throughout.
        run_req("b2b_clear", mk(1, 3'b010, 32'h30, 32'h0, 32'h0, 0, 2));
        @(negedge clock);
        nacc = 0; nrsp = 0;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h30; req_wdata = 32'h000000AA;
        for (int c = 0; c < 40 && nrsp < 3; c++) begin
            acc = req_ready && req_valid;
            if (rsp_valid) nrsp++;
            @(posedge clock);
            #1;
            if (acc) begin
                acc_cyc[nacc] = c;
                nacc++;
                case (nacc)
                    1: begin req_addr = 32'h31; req_wdata = 32'h000000BB; end
                    2: begin req_addr = 32'h30; req_wdata = 32'h000000CC; end
                    default: req_valid = 1'b0;
                endcase
            end
            @(negedge clock);
        end
        req_valid = 1'b0;
        check("b2b_accepts",   nacc, 3);
        check("b2b_responses", nrsp, 3);
        if (nacc == 3) begin
            check("b2b_gap1", acc_cyc[1] - acc_cyc[0], 4);
            check("b2b_gap2", acc_cyc[2] - acc_cyc[1], 4);
        end
        run_req("b2b_readback", mk(0, 3'b010, 32'h30, 32'h0, 32'h0000BBCC, 0, 2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global bound so a stuck design cannot hang the run.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
